// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, plus iterative unsigned
// multiply (shift-add) and restoring divide, one bit per cycle.
// Outputs are registered and only updated on the cycle that done pulses.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             eq,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [3:0] OP_MULU = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    // hi/lo hold the partial product (MUL) or remainder/quotient (DIV)
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic             eq_pend_reg, eq_pend_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] result_hi_reg, result_hi_next;
    logic             eq_reg, eq_next;
    logic             zero_reg, zero_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] single_lo, single_hi;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, div_hi, div_lo;

    // Single-cycle results from the live inputs (used only on the accepting edge)
    always_comb begin
        single_lo = '0;
        single_hi = '0;
        case (op)
            4'b0000: single_lo = in_a;
            4'b0001: single_lo = ~in_a;
            4'b0010: single_lo = in_a + in_b;
            4'b0011: single_lo = in_a - in_b;
            4'b0100: single_lo = in_a | in_b;
            4'b0101: single_lo = in_a & in_b;
            4'b0111: single_lo = (in_a < in_b) ? WIDTH'(1) : '0;
            4'b1001: single_lo = in_b;
            // Only reached here when the divisor is zero
            OP_DIVU: begin
                single_lo = '1;
                single_hi = in_a;
            end
            default: begin
                single_lo = '0;
                single_hi = '0;
            end
        endcase
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo_reg[WIDTH-1:1]};
        // The remainder is always below the divisor, so the shifted value fits WIDTH+1 bits
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_reg});
        div_diff  = div_shift[WIDTH-1:0] - opb_reg;
        div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_lo    = {lo_reg[WIDTH-2:0], div_ge};
    end

    // Next-state and datapath control
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        opb_next       = opb_reg;
        eq_pend_next   = eq_pend_reg;
        result_next    = result_reg;
        result_hi_next = result_hi_reg;
        eq_next        = eq_reg;
        zero_next      = zero_reg;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    eq_pend_next = (in_a == in_b);
                    opb_next     = in_b;
                    hi_next      = '0;
                    lo_next      = in_a;
                    cnt_next     = '0;
                    if (op == OP_MULU) begin
                        state_next = MUL;
                    end else if (op == OP_DIVU && in_b != '0) begin
                        state_next = DIV;
                    end else begin
                        result_next    = single_lo;
                        result_hi_next = single_hi;
                        eq_next        = (in_a == in_b);
                        zero_next      = (single_lo == '0);
                        done_next      = 1'b1;
                    end
                end
            end
            MUL: begin
                hi_next  = mul_hi;
                lo_next  = mul_lo;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ITER) begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    result_next    = mul_lo;
                    result_hi_next = mul_hi;
                    eq_next        = eq_pend_reg;
                    zero_next      = (mul_lo == '0);
                    done_next      = 1'b1;
                end
            end
            DIV: begin
                hi_next  = div_hi;
                lo_next  = div_lo;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ITER) begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    result_next    = div_lo;
                    result_hi_next = div_hi;
                    eq_next        = eq_pend_reg;
                    zero_next      = (div_lo == '0);
                    done_next      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset wins over any simultaneous start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            opb_reg       <= '0;
            eq_pend_reg   <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            eq_reg        <= 1'b0;
            zero_reg      <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            opb_reg       <= opb_next;
            eq_pend_reg   <= eq_pend_next;
            result_reg    <= result_next;
            result_hi_reg <= result_hi_next;
            eq_reg        <= eq_next;
            zero_reg      <= zero_next;
            done_reg      <= done_next;
        end
    end

    assign result    = result_reg;
    assign result_hi = result_hi_reg;
    assign eq        = eq_reg;
    assign zero      = zero_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=32).
module tb_multicycle_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] in_a, in_b;
    logic [31:0] result, result_hi;
    logic        eq, zero, busy, done;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        eq;
        logic        zero;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .result(result), .result_hi(result_hi), .eq(eq), .zero(zero),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        e.res = 32'h0;
        e.hi  = 32'h0;
        case (o)
            4'b0000: e.res = a;
            4'b0001: e.res = ~a;
            4'b0010: e.res = a + b;
            4'b0011: e.res = a - b;
            4'b0100: e.res = a | b;
            4'b0101: e.res = a & b;
            4'b0111: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1001: e.res = b;
            4'b1010: begin
                p = {32'h0, a} * {32'h0, b};
                e.res = p[31:0];
                e.hi  = p[63:32];
            end
            4'b1011: begin
                if (b == 32'h0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.hi  = a;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                end
            end
            default: ;
        endcase
        e.eq   = (a == b);
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] o, input logic [31:0] b);
        if (o == 4'b1010 || (o == 4'b1011 && b != 32'h0)) return 33;
        return 1;
    endfunction

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", {32'h0, result}, {32'h0, e.res});
                check("result_hi", {32'h0, result_hi}, {32'h0, e.hi});
                check("eq", {63'h0, eq}, {63'h0, e.eq});
                check("zero", {63'h0, zero}, {63'h0, e.zero});
                check("busy_at_done", {63'h0, busy}, 64'd0);
                $display("txn done: result=%h result_hi=%h eq=%0d zero=%0d", result, result_hi, eq, zero);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns just after the accepting edge
    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        in_a  = a;
        in_b  = b;
        sb_q.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'($urandom);
        in_a  = $urandom;
        in_b  = $urandom;
    endtask

    // Counts cycles until done, checking busy in between; ends at the done negedge
    task automatic wait_done(input string tag, input int exp_cycles);
        int lat;
        int busy_bad;
        lat = 0;
        busy_bad = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (busy !== 1'b1) busy_bad++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_cycles));
        check({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        send(o, a, b);
        wait_done(tag, exp_lat(o, b));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 4'h0;
        in_a  = 32'h0;
        in_b  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_result", {32'h0, result}, 64'd0);
        check("rst_result_hi", {32'h0, result_hi}, 64'd0);
        check("rst_eq", {63'h0, eq}, 64'd0);
        check("rst_zero", {63'h0, zero}, 64'd1);
        check("rst_busy", {63'h0, busy}, 64'd0);
        check("rst_done", {63'h0, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Truncating add
        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd2);
        // Full-width multiply
        run_op("mulu_max", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // Divide, then divide by zero back-to-back on the done cycle
        run_op("divu", 4'b1011, 32'd100, 32'd7);
        run_op("divu_zero", 4'b1011, 32'd100, 32'd0);
        // Compare-equal then back-to-back load of B
        run_op("sltu_eq", 4'b0111, 32'd3, 32'd3);
        run_op("load_b", 4'b1001, 32'd3, 32'd9);

        // A start while busy must be ignored
        send(4'b1010, 32'h1234_5678, 32'h0000_9ABC);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 4'b0011;
        in_a  = 32'd50;
        in_b  = 32'd8;
        @(negedge clk);
        start = 1'b0;
        wait_done("mul_ignore", 28);
        repeat (3) @(negedge clk);

        // Reset in the middle of a divide aborts it with no done
        send(4'b1011, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'h0, busy}, 64'd0);
        check("abort_result", {32'h0, result}, 64'd0);
        check("abort_zero", {63'h0, zero}, 64'd1);
        check("abort_done", {63'h0, done}, 64'd0);
        repeat (40) @(negedge clk);
        run_op("after_abort", 4'b0000, 32'd5, 32'd0);

        // Reset takes priority over a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        op    = 4'b1010;
        in_a  = 32'd7;
        in_b  = 32'd7;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {63'h0, busy}, 64'd0);
        check("rst_start_done", {63'h0, done}, 64'd0);
        repeat (40) @(negedge clk);

        // Random back-to-back mix over every opcode
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  o;
            logic [31:0] a, b;
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom_range(1, 3) == 1 ? a : $urandom;
            if (i % 5 == 0) b = 32'($urandom_range(1, 20));
            run_op("random", o, a, b);
        end
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
